// File: rtl/intr_pkg.sv
// Shared definitions for the two-line interrupt controller:
// FSM state encoding and the default inter-interrupt gap.
package intr_pkg;

    localparam int GAP_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/intr_sync.sv
// One interrupt line: 2-flop synchronizer plus a third flop, flagging
// a rising edge for one cycle when stage 2 is high and stage 3 is low.
module intr_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic stage1;
    logic stage2;
    logic stage3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1 <= 1'b0;
            stage2 <= 1'b0;
            stage3 <= 1'b0;
        end else begin
            stage1 <= async_in;
            stage2 <= stage1;
            stage3 <= stage2;
        end
    end

    assign rise = stage2 & ~stage3;

endmodule

// File: rtl/intr_ctrl.sv
// Two-line interrupt controller: edge-triggered pending flags, fixed
// priority (line 0 first), one-cycle pulses separated by GAP hold cycles.
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int GAP = GAP_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] irq_in,
    input  logic [1:0] mask,
    output logic       intr1,
    output logic       intr2,
    output logic [1:0] pending,
    output logic       busy
);

    logic [1:0] rise;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] clear;
    state_t     state;
    state_t     state_next;
    logic [7:0] hold_cnt;
    logic [7:0] hold_next;

    intr_sync u_sync0 (
        .clk      (clk),
        .reset    (reset),
        .async_in (irq_in[0]),
        .rise     (rise[0])
    );

    intr_sync u_sync1 (
        .clk      (clk),
        .reset    (reset),
        .async_in (irq_in[1]),
        .rise     (rise[1])
    );

    // Mask only matters here, in IDLE, when a line is granted.
    always_comb begin
        req        = pending & mask;
        grant      = 2'b00;
        clear      = 2'b00;
        state_next = state;
        hold_next  = hold_cnt;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_next = ISSUE;
                    clear      = grant;
                end
            end
            ISSUE: begin
                state_next = HOLD;
                hold_next  = 8'(GAP - 1);
            end
            HOLD: begin
                if (hold_cnt == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    hold_next = hold_cnt - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A new edge on the line being cleared keeps it pending (set wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= 8'd0;
            pending  <= 2'b00;
            intr1    <= 1'b0;
            intr2    <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            pending  <= (pending & ~clear) | rise;
            intr1    <= clear[0];
            intr2    <= clear[1];
        end
    end

    assign busy = (state == ISSUE) || (state == HOLD);

endmodule
